// File: rtl/eyeriss_pkg.sv
// Shared Eyeriss definitions: default datapath widths and the ofmap dump FSM state encoding.
package eyeriss_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_M_WIDTH    = 10;
  localparam int DEF_N_WIDTH    = 3;
  localparam int DEF_E_WIDTH    = 6;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    STREAM,
    DRAIN,
    DONE
  } dump_state_e;

endpackage

// File: rtl/ofmap_out_fifo.sv
// Two-entry output FIFO for the ofmap dumper; the payload is a psum word with its image/filter tags and last flag.
module ofmap_out_fifo
  import eyeriss_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int M_WIDTH    = DEF_M_WIDTH,
  parameter int N_WIDTH    = DEF_N_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic [N_WIDTH-1:0]    push_img_i,
  input  logic [M_WIDTH-1:0]    push_filt_i,
  input  logic                  push_last_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic [N_WIDTH-1:0]    head_img_o,
  output logic [M_WIDTH-1:0]    head_filt_o,
  output logic                  head_last_o,
  output logic [1:0]            count_o
);

  localparam int PW = DATA_WIDTH + N_WIDTH + M_WIDTH + 1;

  logic [PW-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q;

  // The producer never pushes into a full FIFO, so a push never overwrites the head being held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= {push_data_i, push_img_i, push_filt_i, push_last_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign {head_data_o, head_img_o, head_filt_o, head_last_o} = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/ofmap_dumper.sv
// Streams a block of psums from the GLB to a ready/valid output, tagging each word with image and filter id.
// Define OFMAP_DUMPER_RELU_EN to clamp negative psums to zero on the way out.
module ofmap_dumper
  import eyeriss_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int M_WIDTH    = DEF_M_WIDTH,
  parameter int N_WIDTH    = DEF_N_WIDTH,
  parameter int E_WIDTH    = DEF_E_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ofmap_dump,
  output logic                    dump_done,
  input  logic [1:0][N_WIDTH-1:0] psum_ids,
  input  logic [1:0][M_WIDTH-1:0] psum_channel_ids,
  input  logic [E_WIDTH-1:0]      e,
  input  logic [E_WIDTH-1:0]      E,
  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_last,
  output logic [N_WIDTH-1:0]      out_image_id,
  output logic [M_WIDTH-1:0]      out_filter_id
);

  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] d);
`ifdef OFMAP_DUMPER_RELU_EN
    logic signed [DATA_WIDTH-1:0] s;
    s = d;
    return (s < 0) ? '0 : d;
`else
    return d;
`endif
  endfunction

  dump_state_e state_q, state_d;

  logic [N_WIDTH-1:0]    n0_q, n0_d, n1_q, n1_d, img_q, img_d;
  logic [M_WIDTH-1:0]    m0_q, m0_d, m1_q, m1_d, filt_q, filt_d;
  logic [E_WIDTH-1:0]    rows_q, rows_d, cols_q, cols_d;
  logic [E_WIDTH-1:0]    row_q, row_d, col_q, col_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic                  vld_p0;
  logic [N_WIDTH-1:0]    img_p0;
  logic [M_WIDTH-1:0]    filt_p0;
  logic                  last_p0;

  logic       pop;
  logic [1:0] fifo_count;
  logic [2:0] occ;
  logic       credit_ok;
  logic       col_end, row_end, filt_end, img_end, last_rd;

  // Occupancy counts words in the FIFO plus the read in flight, net of this cycle's pop.
  assign pop       = out_valid & out_ready;
  assign occ       = 3'(fifo_count) + 3'(vld_p0) - 3'(pop);
  assign credit_ok = (occ < 3'd2);

  assign col_end  = (col_q  == cols_q - E_WIDTH'(1));
  assign row_end  = (row_q  == rows_q - E_WIDTH'(1));
  assign filt_end = (filt_q == m1_q);
  assign img_end  = (img_q  == n1_q);
  assign last_rd  = col_end & row_end & filt_end & img_end;

  assign rd_addr = addr_q;

  always_comb begin
    state_d   = state_q;
    n0_d      = n0_q;
    n1_d      = n1_q;
    m0_d      = m0_q;
    m1_d      = m1_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    img_d     = img_q;
    filt_d    = filt_q;
    row_d     = row_q;
    col_d     = col_q;
    addr_d    = addr_q;
    rd_en     = 1'b0;
    dump_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (ofmap_dump) begin
          n0_d    = psum_ids[0];
          n1_d    = psum_ids[1];
          m0_d    = psum_channel_ids[0];
          m1_d    = psum_channel_ids[1];
          rows_d  = e;
          cols_d  = E;
          img_d   = psum_ids[0];
          filt_d  = psum_channel_ids[0];
          row_d   = '0;
          col_d   = '0;
          addr_d  = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if ((n1_q < n0_q) || (m1_q < m0_q) || (rows_q == '0) || (cols_q == '0))
          state_d = DONE;
        else
          state_d = STREAM;
      end
      STREAM: begin
        if (credit_ok) begin
          rd_en  = 1'b1;
          addr_d = addr_q + ADDR_WIDTH'(1);
          // Column is innermost, then row, filter id, image id; each wraps by compare-to-limit.
          if (!col_end) begin
            col_d = col_q + E_WIDTH'(1);
          end else begin
            col_d = '0;
            if (!row_end) begin
              row_d = row_q + E_WIDTH'(1);
            end else begin
              row_d = '0;
              if (!filt_end) begin
                filt_d = filt_q + M_WIDTH'(1);
              end else begin
                filt_d = m0_q;
                img_d  = img_end ? n0_q : img_q + N_WIDTH'(1);
              end
            end
          end
          if (last_rd) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) state_d = DONE;
      end
      DONE: begin
        dump_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      n0_q    <= '0;
      n1_q    <= '0;
      m0_q    <= '0;
      m1_q    <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      img_q   <= '0;
      filt_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      n0_q    <= n0_d;
      n1_q    <= n1_d;
      m0_q    <= m0_d;
      m1_q    <= m1_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      img_q   <= img_d;
      filt_q  <= filt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
    end
  end

  // p0: tags travel alongside the GLB read, whose data returns one cycle after rd_en.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0  <= 1'b0;
      img_p0  <= '0;
      filt_p0 <= '0;
      last_p0 <= 1'b0;
    end else begin
      vld_p0  <= rd_en;
      img_p0  <= img_q;
      filt_p0 <= filt_q;
      last_p0 <= rd_en & last_rd;
    end
  end

  ofmap_out_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .M_WIDTH    (M_WIDTH),
    .N_WIDTH    (N_WIDTH)
  ) u_out_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (vld_p0),
    .push_data_i (relu(rd_data)),
    .push_img_i  (img_p0),
    .push_filt_i (filt_p0),
    .push_last_i (last_p0),
    .pop_i       (pop),
    .valid_o     (out_valid),
    .head_data_o (out_data),
    .head_img_o  (out_image_id),
    .head_filt_o (out_filter_id),
    .head_last_o (out_last),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_ofmap_dumper.sv
// Directed scoreboard bench for ofmap_dumper: GLB model, ready patterns, empty range, mid-dump reset and request drop.
module tb_ofmap_dumper;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int MW = 10;
  localparam int NW = 3;
  localparam int EW = 6;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               ofmap_dump;
  logic               dump_done;
  logic [1:0][NW-1:0] psum_ids;
  logic [1:0][MW-1:0] psum_channel_ids;
  logic [EW-1:0]      e_rows;
  logic [EW-1:0]      E_cols;
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic [DW-1:0]      rd_data;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic               out_last;
  logic [NW-1:0]      out_image_id;
  logic [MW-1:0]      out_filter_id;

  ofmap_dumper dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ofmap_dump       (ofmap_dump),
    .dump_done        (dump_done),
    .psum_ids         (psum_ids),
    .psum_channel_ids (psum_channel_ids),
    .e                (e_rows),
    .E                (E_cols),
    .rd_en            (rd_en),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_last         (out_last),
    .out_image_id     (out_image_id),
    .out_filter_id    (out_filter_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [NW-1:0] img;
    logic [MW-1:0] filt;
    logic          last;
  } word_t;

  word_t         sb[$];
  logic [DW-1:0] glb [0:63];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            reads, words, dones, exp_addr;
  int            first_rd_cyc, first_out_cyc, last_out_cyc, done_cyc, start_cyc;
  bit            hold;
  word_t         held;
  bit            ready_toggle;
  logic [DW-1:0] first_data;
  logic [DW-1:0] relu_first;

  always @(posedge clk) cyc <= cyc + 1;

  // GLB read port: data one cycle after rd_en, garbage otherwise
  always @(posedge clk) rd_data <= rd_en ? glb[rd_addr[5:0]] : 16'hDEAD;

  always @(posedge clk) begin
    #1;
    out_ready = ready_toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
  end

  function automatic logic [DW-1:0] relu_m(input logic [DW-1:0] d);
`ifdef OFMAP_DUMPER_RELU_EN
    return d[DW-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'(out_data), 64'(held.data));
        chk("stall_tags", 64'({out_image_id, out_filter_id, out_last}),
            64'({held.img, held.filt, held.last}));
      end
      if (rd_en) begin
        chk("rd_addr", 64'(rd_addr), 64'(exp_addr));
        if (reads == 0) first_rd_cyc = cyc;
        exp_addr++;
        reads++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_word observed=%0h expected=none", out_data);
        end else begin
          word_t w;
          w = sb.pop_front();
          chk("out_data", 64'(out_data), 64'(w.data));
          chk("out_image_id", 64'(out_image_id), 64'(w.img));
          chk("out_filter_id", 64'(out_filter_id), 64'(w.filt));
          chk("out_last", 64'(out_last), 64'(w.last));
        end
        if (words == 0) begin
          first_out_cyc = cyc;
          first_data    = out_data;
        end
        last_out_cyc = cyc;
        words++;
      end
      hold = out_valid && !out_ready;
      if (hold) held = {out_data, out_image_id, out_filter_id, out_last};
      if (dump_done) begin
        dones++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_dump(input int n0, input int n1, input int m0, input int m1,
                            input int ee, input int EE);
    int    a;
    word_t w;
    reads    = 0;
    words    = 0;
    dones    = 0;
    exp_addr = 0;
    a        = 0;
    for (int n = n0; n <= n1; n++)
      for (int m = m0; m <= m1; m++)
        for (int r = 0; r < ee; r++)
          for (int c = 0; c < EE; c++) begin
            w.data = relu_m(glb[a]);
            w.img  = NW'(n);
            w.filt = MW'(m);
            w.last = (n == n1) && (m == m1) && (r == ee - 1) && (c == EE - 1);
            sb.push_back(w);
            a++;
          end
    @(posedge clk);
    #1;
    psum_ids         = {NW'(n1), NW'(n0)};
    psum_channel_ids = {MW'(m1), MW'(m0)};
    e_rows           = EW'(ee);
    E_cols           = EW'(EE);
    ofmap_dump       = 1'b1;
    start_cyc        = cyc;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dump_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    ofmap_dump = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ready_toggle     = 1'b0;
    reset_n          = 1'b0;
    ofmap_dump       = 1'b0;
    psum_ids         = '0;
    psum_channel_ids = '0;
    e_rows           = '0;
    E_cols           = '0;
    for (int i = 0; i < 64; i++) glb[i] = DW'($urandom);
    glb[0] = 16'hFFF0;
    glb[3] = 16'h8000;
    glb[5] = 16'h7FFF;
`ifdef OFMAP_DUMPER_RELU_EN
    relu_first = 16'h0000;
`else
    relu_first = 16'hFFF0;
`endif

    repeat (3) @(negedge clk);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_dump_done", 64'(dump_done), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_out_data_ids", 64'({out_data, out_image_id, out_filter_id}), 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Basic dump, ready held high; range inputs scrambled after capture
    start_dump(1, 1, 1, 2, 2, 3);
    @(posedge clk);
    #1;
    psum_ids         = {NW'(0), NW'(7)};
    psum_channel_ids = '1;
    e_rows           = '0;
    E_cols           = EW'(1);
    wait_done(200, "t1");
    chk("t1_words", 64'(words), 64'd12);
    chk("t1_reads", 64'(reads), 64'd12);
    chk("t1_dones", 64'(dones), 64'd1);
    chk("t1_sb_left", 64'(sb.size()), 64'd0);
    chk("t1_first_latency", 64'(first_out_cyc - first_rd_cyc), 64'd2);
    chk("t1_throughput", 64'(last_out_cyc - first_out_cyc), 64'd11);
    chk("t1_relu_word0", 64'(first_data), 64'(relu_first));

    // Same dump under a 1,0,0,1 ready pattern
    ready_toggle = 1'b1;
    start_dump(1, 1, 1, 2, 2, 3);
    wait_done(400, "t2");
    chk("t2_words", 64'(words), 64'd12);
    chk("t2_reads", 64'(reads), 64'd12);
    chk("t2_dones", 64'(dones), 64'd1);
    chk("t2_sb_left", 64'(sb.size()), 64'd0);
    ready_toggle = 1'b0;
    repeat (2) @(negedge clk);

    // Empty filter range: no reads, done two cycles after the request
    start_dump(1, 1, 3, 2, 2, 3);
    wait_done(20, "t3");
    chk("t3_reads", 64'(reads), 64'd0);
    chk("t3_done_delay", 64'(done_cyc - start_cyc), 64'd2);
    chk("t3_dones", 64'(dones), 64'd1);
    chk("t3_words", 64'(words), 64'd0);

    // Reset after five accepted words, then a fresh dump
    start_dump(1, 1, 1, 2, 2, 3);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (words >= 5) break;
    end
    @(posedge clk);
    #1;
    reset_n    = 1'b0;
    ofmap_dump = 1'b0;
    @(negedge clk);
    chk("t4_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t4_rst_rd_en", 64'(rd_en), 64'd0);
    chk("t4_rst_dump_done", 64'(dump_done), 64'd0);
    chk("t4_rst_rd_addr", 64'(rd_addr), 64'd0);
    repeat (4) @(negedge clk);
    chk("t4_no_done", 64'(dones), 64'd0);
    chk("t4_words_before_reset", 64'(words), 64'd5);
    sb.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_idle_after_reset", 64'({rd_en, out_valid, dump_done}), 64'd0);
    start_dump(1, 1, 1, 2, 2, 3);
    wait_done(200, "t4b");
    chk("t4b_words", 64'(words), 64'd12);
    chk("t4b_reads", 64'(reads), 64'd12);
    chk("t4b_dones", 64'(dones), 64'd1);

    // Request dropped after the first read
    start_dump(1, 1, 1, 2, 2, 3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_en === 1'b1) break;
    end
    ofmap_dump = 1'b0;
    wait_done(200, "t6");
    chk("t6_words", 64'(words), 64'd12);
    chk("t6_reads", 64'(reads), 64'd12);
    chk("t6_dones", 64'(dones), 64'd1);
    chk("t6_sb_left", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofmap_dumper.md
OFMAP_DUMPER -- requirements
Module: ofmap_dumper

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_WIDTH, 16, psum word width; ADDR_WIDTH, 12, psum GLB address width; M_WIDTH, 10, filter id width; N_WIDTH, 3, image id width; E_WIDTH, 6, ofmap row/column count width.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports listed as name, direction, width, meaning.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ofmap_dump, input, 1, level request from the scheduler, held until dump_done.
REQ-006 SHALL have port dump_done, output, 1, one-cycle completion pulse to the scheduler.
REQ-007 SHALL have port psum_ids, input, 2xN_WIDTH, first/last image id of the dump, inclusive.
REQ-008 SHALL have port psum_channel_ids, input, 2xM_WIDTH, first/last filter id of the dump, inclusive.
REQ-009 SHALL have port e, input, E_WIDTH, ofmap rows held in the GLB for this dump.
REQ-010 SHALL have port E, input, E_WIDTH, ofmap width in columns.
REQ-011 SHALL have the psum GLB read ports: rd_en, output, 1; rd_addr, output, ADDR_WIDTH; rd_data, input, DATA_WIDTH, valid exactly one cycle after rd_en.
REQ-012 SHALL have the output stream ports: out_valid, output, 1; out_ready, input, 1; out_data, output, DATA_WIDTH; out_last, output, 1, marks the final word; out_image_id, output, N_WIDTH; out_filter_id, output, M_WIDTH.

Function
REQ-013 SHALL implement states IDLE, CHECK, STREAM, DRAIN, DONE.
REQ-014 IDLE: on ofmap_dump=1, capture all range inputs into registers and go to CHECK; inputs SHALL be ignored after capture.
REQ-015 CHECK: if psum_ids[1]<psum_ids[0], psum_channel_ids[1]<psum_channel_ids[0], e==0 or E==0, go to DONE without any read; otherwise go to STREAM.
REQ-016 Word count SHALL be (n1-n0+1)*(m1-m0+1)*e*E; rd_addr SHALL start at 0 and increment by 1 per issued read.
REQ-017 Loop order, innermost first: column (0..E-1), row (0..e-1), filter id (m0..m1), image id (n0..n1); out_image_id/out_filter_id SHALL tag each word.
REQ-018 STREAM: a read SHALL be issued only when the output buffer has a free slot counting in-flight reads; after the last read, go to DRAIN.
REQ-019 With out_ready held high, sustained throughput SHALL be one word per cycle; first out_valid SHALL occur 2 cycles after the first rd_en.
REQ-020 out_data and its tags SHALL stay stable while out_valid=1 and out_ready=0; no word SHALL be dropped or duplicated.
REQ-021 out_last SHALL be 1 only on the final word of the dump.
REQ-022 DRAIN: when the word with out_last is accepted (out_valid & out_ready), go to DONE.
REQ-023 DONE: assert dump_done for exactly one cycle, then go to IDLE.
REQ-024 ofmap_dump falling mid-dump SHALL be ignored and the dump SHALL complete.
REQ-025 Counter wrap SHALL be by compare-to-limit, never by natural overflow; counters SHALL be sized for ranges up to their full width.

Reset
REQ-026 reset_n=0 SHALL asynchronously force IDLE and clear all counters and buffers.
REQ-027 During reset, rd_en, out_valid, out_last and dump_done SHALL be 0, and all other outputs SHALL be 0.
REQ-028 Reset asserted mid-dump SHALL abandon the dump and produce no dump_done.

Configuration
REQ-029 With OFMAP_DUMPER_RELU_EN defined, out_data SHALL be 0 whenever the signed psum is negative; without it, out_data SHALL equal rd_data unchanged.

Structure
REQ-030 The state enum and the default widths SHALL live in a shared package, eyeriss_pkg.
REQ-031 The output buffer SHALL be a 2-entry FIFO sub-module, ofmap_out_fifo, whose payload is data, ids and last.

Verification
REQ-032 ids {1,1}, filters {1,2}, e=2, E=3, out_ready=1: expect 12 words, addresses 0..11, out_last on word 12, one dump_done pulse.
REQ-033 Same dump with out_ready toggling 1,0,0,1 repeatedly: expect identical data sequence, out_data stable during stalls, no loss.
REQ-034 Filters {3,2}: expect no rd_en and dump_done exactly 2 cycles after ofmap_dump rises.
REQ-035 reset_n pulsed low after 5 accepted words, then a fresh request: expect no dump_done for the first dump and a full 12-word dump from address 0 for the second.
REQ-036 rd_data=16'hFFF0 with OFMAP_DUMPER_RELU_EN defined: expect out_data=0; without the macro: expect out_data=16'hFFF0.
REQ-037 ofmap_dump deasserted after the first read: expect the dump to complete with all words and one dump_done.
